// File: rtl/picomips_pkg.sv
`default_nettype none
// ============================================================================
// Package : picomips_pkg
// Opcodes, flag record and decode helpers for the picoMIPS pipeline.
// Revision: 1.0
// ============================================================================
package picomips_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADDI = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_MULI = 4'd7,
    OP_IN   = 4'd8,
    OP_OUT  = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_JMP  = 4'd12,
    OP_HALT = 4'd15
  } opcode_t;

  typedef struct packed {
    logic z;
    logic n;
  } flags_t;

  // A NOP word is this opcode with every operand field zero.
  localparam opcode_t NOP_OP = OP_NOP;

  function automatic logic is_alu_op(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_AND, OP_OR, OP_XOR, OP_MULI};
  endfunction

endpackage
`default_nettype wire

// File: rtl/picomips_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : picomips_pipe_if
// Program ROM port plus valid/ready data-in and data-out channels.
// Revision: 1.0
// ============================================================================
interface picomips_pipe_if #(
  parameter int N     = 8,
  parameter int NREG  = 8,
  parameter int PSIZE = 6
);
  localparam int RA = $clog2(NREG);
  localparam int IW = 4 + 2 * RA + N;

  logic [PSIZE-1:0] imem_addr;
  logic [IW-1:0]    imem_data;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/picomips_alu.sv
`default_nettype none
// ============================================================================
// Module : picomips_alu
// Combinational ALU; result is zero for opcodes that are not ALU operations.
// Revision: 1.0
// ============================================================================
module picomips_alu
  import picomips_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  opcode_t      i_op,
  output logic [N-1:0] o_result,
  output flags_t       o_flags
);

  logic [2*N-1:0] w_prod;

  // Signed Q1.(N-1) multiply: keep product bits [2N-2:N-1].
  assign w_prod = {{N{i_a[N-1]}}, i_a} * {{N{i_b[N-1]}}, i_b};

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD, OP_ADDI: o_result = i_a + i_b;
      OP_SUB:          o_result = i_a - i_b;
      OP_AND:          o_result = i_a & i_b;
      OP_OR:           o_result = i_a | i_b;
      OP_XOR:          o_result = i_a ^ i_b;
      OP_MULI:         o_result = N'(w_prod >> (N - 1));
      default:         o_result = '0;
    endcase
  end

  assign o_flags.z = (o_result == '0);
  assign o_flags.n = o_result[N-1];

endmodule
`default_nettype wire

// File: rtl/picomips_pipe.sv
`default_nettype none
// ============================================================================
// Module : picomips_pipe
// Two-stage fetch/execute picoMIPS core with handshaked I/O, branches and HALT.
// Revision: 1.0
// ============================================================================
module picomips_pipe
  import picomips_pkg::*;
#(
  parameter int N     = 8,
  parameter int NREG  = 8,
  parameter int PSIZE = 6
) (
  input  logic           clk,
  input  logic           reset,
  picomips_pipe_if.master bus,
  output logic           halted,
  output logic [N-1:0]   dbg_result
);

  localparam int RA = $clog2(NREG);
  localparam int IW = 4 + 2 * RA + N;
  localparam logic [IW-1:0] NOP_WORD = {NOP_OP, {(IW - 4){1'b0}}};

  logic [PSIZE-1:0] r_pc;
  logic [IW-1:0]    r_ir;
  logic [N-1:0]     r_regs [NREG];
  flags_t           r_flags;
  logic             r_halted;

  opcode_t          w_op;
  logic [RA-1:0]    w_rd;
  logic [RA-1:0]    w_rs;
  logic [N-1:0]     w_imm;
  logic [N-1:0]     w_a;
  logic [N-1:0]     w_rs_val;
  logic [N-1:0]     w_b;
  logic [N-1:0]     w_result;
  flags_t           w_flags;
  logic             w_stall;
  logic             w_taken;
  logic             w_wr_en;
  logic [N-1:0]     w_wr_data;

  assign w_op  = opcode_t'(r_ir[IW-1 -: 4]);
  assign w_rd  = r_ir[IW-5 -: RA];
  assign w_rs  = r_ir[IW-5-RA -: RA];
  assign w_imm = r_ir[N-1:0];

  assign w_a      = (w_rd == '0) ? '0 : r_regs[w_rd];
  assign w_rs_val = (w_rs == '0) ? '0 : r_regs[w_rs];
  assign w_b      = (w_op == OP_ADDI || w_op == OP_MULI) ? w_imm : w_rs_val;

  picomips_alu #(.N(N)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  // A stalled instruction stays in E: PC, IR, registers and flags all hold.
  always_comb begin
    w_stall = 1'b0;
    w_taken = 1'b0;
    case (w_op)
      OP_IN:   w_stall = !bus.in_valid;
      OP_OUT:  w_stall = !bus.out_ready;
      OP_HALT: w_stall = 1'b1;
      OP_BEQ:  w_taken = r_flags.z;
      OP_BNE:  w_taken = !r_flags.z;
      OP_JMP:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_wr_en   = !w_stall && (is_alu_op(w_op) || w_op == OP_IN) && (w_rd != '0);
  assign w_wr_data = (w_op == OP_IN) ? bus.in_data : w_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_ir     <= NOP_WORD;
      r_flags  <= '0;
      r_halted <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_op == OP_HALT) r_halted <= 1'b1;
      if (!w_stall) begin
        if (w_taken) begin
          r_pc <= w_imm[PSIZE-1:0];
          r_ir <= NOP_WORD;
        end else begin
          r_pc <= r_pc + PSIZE'(1);
          r_ir <= bus.imem_data;
        end
        if (is_alu_op(w_op)) r_flags <= w_flags;
      end
      if (w_wr_en) r_regs[w_rd] <= w_wr_data;
    end
  end

  // Handshake outputs decode only from IR, so no input-to-output comb path.
  assign bus.imem_addr = r_pc;
  assign bus.in_ready  = (w_op == OP_IN);
  assign bus.out_valid = (w_op == OP_OUT);
  assign bus.out_data  = w_rs_val;
  assign halted        = r_halted;
  assign dbg_result    = w_result;

endmodule
`default_nettype wire

// File: tb/tb_picomips_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_picomips_pipe
// Directed timing scenarios plus random programs against an ISA-level model.
// Revision: 1.0
// ============================================================================
module tb_picomips_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       halted;
  logic [7:0] dbg_result;

  picomips_pipe_if #(.N(8), .NREG(8), .PSIZE(6)) bus ();

  picomips_pipe #(.N(8), .NREG(8), .PSIZE(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .halted     (halted),
    .dbg_result (dbg_result)
  );

  always #5 clk = ~clk;

  logic [17:0] rom [64];
  logic [7:0]  in_list [64];
  int          in_idx;
  logic [7:0]  outq [$];
  logic [7:0]  exp_q [$];
  int          exp_halt_addr;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        rand_hs = 1'b0;

  assign bus.imem_data = rom[bus.imem_addr];
  assign bus.in_data   = in_list[in_idx[5:0]];

  // Observe completed transfers at the active edge (nonblocking to avoid racing the DUT).
  always @(posedge clk) begin
    if (reset) begin
      in_idx <= 0;
      outq.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) in_idx <= in_idx + 1;
      if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 64; i++) rom[i] = enc(4'd15, 3'd0, 3'd0, 8'd0);
  endtask

  task automatic step();
    @(negedge clk);
    if (rand_hs) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_prog(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      step();
      cycles++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  // Instruction-level interpreter: architectural effects only, no cycle timing.
  task automatic model_run();
    logic [7:0]  r [8];
    logic        z;
    int          pc, k, p;
    logic [17:0] ins;
    logic [3:0]  op;
    logic [2:0]  rd, rs;
    logic [7:0]  imm, a, b, res;
    exp_q.delete();
    exp_halt_addr = -1;
    pc = 0; k = 0; z = 1'b0;
    foreach (r[i]) r[i] = 8'd0;
    for (int s = 0; s < 2000; s++) begin
      ins = rom[pc];
      op = ins[17:14]; rd = ins[13:11]; rs = ins[10:8]; imm = ins[7:0];
      a = r[rd]; b = r[rs]; res = 8'd0;
      if (op == 4'd15) begin
        exp_halt_addr = (pc + 1) % 64;
        break;
      end
      case (op)
        4'd1: res = a + b;
        4'd2: res = a - b;
        4'd3: res = a + imm;
        4'd4: res = a & b;
        4'd5: res = a | b;
        4'd6: res = a ^ b;
        4'd7: begin
          p = $signed(a) * $signed(imm);
          res = 8'(p >>> 7);
        end
        4'd8: begin
          res = in_list[k];
          k++;
        end
        4'd9: exp_q.push_back(b);
        default: res = 8'd0;
      endcase
      if (op inside {[4'd1:4'd7]}) z = (res == 8'd0);
      if ((op inside {[4'd1:4'd8]}) && rd != 3'd0) r[rd] = res;
      if ((op == 4'd10 && z) || (op == 4'd11 && !z) || op == 4'd12) pc = int'(imm[5:0]);
      else pc = (pc + 1) % 64;
    end
  endtask

  task automatic gen_prog();
    int         len;
    logic [3:0] op;
    logic [7:0] imm;
    len = $urandom_range(8, 40);
    fill_halt();
    for (int a = 0; a < len - 1; a++) begin
      op  = 4'($urandom_range(0, 14));
      imm = 8'($urandom);
      if (op inside {4'd10, 4'd11, 4'd12}) imm = 8'($urandom_range(a + 1, len - 1));
      rom[a] = enc(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), imm);
    end
    for (int i = 0; i < 64; i++) in_list[i] = 8'($urandom);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    fill_halt();
    for (int i = 0; i < 64; i++) in_list[i] = 8'd0;

    // Countdown loop: BNE taken twice (2 cycles each), then falls through to HALT.
    rom[0] = enc(4'd3, 3'd1, 3'd0, 8'd3);
    rom[1] = enc(4'd3, 3'd1, 3'd0, 8'hFF);
    rom[2] = enc(4'd11, 3'd0, 3'd0, 8'd1);
    do_reset();
    run_prog(200, cyc);
    check("loop_cycles", cyc, 11);
    check("loop_halt_addr", bus.imem_addr, 4);

    // ADDI to zero, then BEQ over an OUT; reset must also clear the previous halt.
    fill_halt();
    rom[0] = enc(4'd3, 3'd1, 3'd0, 8'd5);
    rom[1] = enc(4'd3, 3'd1, 3'd0, 8'hFB);
    rom[2] = enc(4'd10, 3'd0, 3'd0, 8'd5);
    rom[3] = enc(4'd9, 3'd0, 3'd1, 8'd0);
    do_reset();
    check("rst_pc", bus.imem_addr, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_dbg", dbg_result, 0);
    bus.out_ready = 1'b1;
    step();
    check("dbg_addi5", dbg_result, 8'h05);
    step();
    check("dbg_addi_wrap", dbg_result, 8'h00);
    step();
    step();
    check("beq_target_pc", bus.imem_addr, 5);
    run_prog(50, cyc);
    check("beq_halt_cycles", cyc, 2);
    check("beq_skipped_out", outq.size(), 0);
    repeat (3) step();
    check("halt_pc_frozen", bus.imem_addr, 6);

    // IN stall then OUT stall.
    fill_halt();
    rom[0] = enc(4'd8, 3'd2, 3'd0, 8'd0);
    rom[1] = enc(4'd9, 3'd0, 3'd2, 8'd0);
    in_list[0] = 8'h3C;
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("in_stall_pc", bus.imem_addr, 1);
      check("in_stall_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("in_taken_pc", bus.imem_addr, 2);
    for (int i = 0; i < 3; i++) begin
      check("out_stall_valid", bus.out_valid, 1);
      check("out_stall_data", bus.out_data, 8'h3C);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("out_done_valid", bus.out_valid, 0);
    run_prog(20, cyc);
    check("out_transfers", outq.size(), 1);
    if (outq.size() > 0) check("out_value", outq[0], 8'h3C);
    check("in_transfers", in_idx, 1);

    // Q1.7 multiply: 0.5*0.5 and -1*-1 (wraps to -1).
    fill_halt();
    rom[0] = enc(4'd3, 3'd3, 3'd0, 8'h40);
    rom[1] = enc(4'd7, 3'd3, 3'd0, 8'h40);
    rom[2] = enc(4'd9, 3'd0, 3'd3, 8'd0);
    rom[3] = enc(4'd3, 3'd4, 3'd0, 8'h80);
    rom[4] = enc(4'd7, 3'd4, 3'd0, 8'h80);
    rom[5] = enc(4'd9, 3'd0, 3'd4, 8'd0);
    do_reset();
    bus.out_ready = 1'b1;
    step();
    step();
    check("dbg_muli", dbg_result, 8'h20);
    run_prog(50, cyc);
    check("muli_count", outq.size(), 2);
    if (outq.size() == 2) begin
      check("muli_half", outq[0], 8'h20);
      check("muli_wrap", outq[1], 8'h80);
    end

    // Reset in the middle of an IN stall, with in_valid raised on the reset edge.
    fill_halt();
    rom[0] = enc(4'd9, 3'd0, 3'd2, 8'd0);
    rom[1] = enc(4'd8, 3'd2, 3'd0, 8'd0);
    rom[2] = enc(4'd9, 3'd0, 3'd2, 8'd0);
    in_list[0] = 8'h55;
    do_reset();
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("pre_rst_in_ready", bus.in_ready, 1);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    step();
    check("rst_stall_in_ready", bus.in_ready, 0);
    check("rst_stall_pc", bus.imem_addr, 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("rst_stall_out_valid", bus.out_valid, 1);
    check("rst_stall_r2", bus.out_data, 0);

    // Random forward-branching programs with random handshake timing.
    for (int prog = 0; prog < 20; prog++) begin
      gen_prog();
      model_run();
      do_reset();
      rand_hs = 1'b1;
      run_prog(3000, cyc);
      rand_hs = 1'b0;
      check("rnd_out_count", outq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        if (i < outq.size()) check("rnd_out_data", outq[i], exp_q[i]);
      check("rnd_halt_addr", bus.imem_addr, exp_halt_addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
